// File: rtl/wordle_scorer.sv
// Wordle scorer: greens then yellows, one letter per cycle, result stored in a 6-row colour board.
// Latency: 11 cycles from accepted start to the done pulse. start is ignored while busy and never queued.
module wordle_scorer #(
    parameter int NUM_LETTERS = 5,
    parameter int NUM_ROWS    = 6,
    parameter int LETTER_W    = 8
) (
    input  logic                            Clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_LETTERS*LETTER_W-1:0] guess,
    input  logic [NUM_LETTERS*LETTER_W-1:0] answer,
    input  logic [2:0]                      row,
    input  logic                            clear_board,
    output logic                            busy,
    output logic                            done,
    output logic [2*NUM_LETTERS-1:0]        colors,
    output logic                            win,
    input  logic [2:0]                      rd_row,
    output logic [2*NUM_LETTERS-1:0]        rd_colors
);

    localparam int WORD_W = NUM_LETTERS * LETTER_W;
    localparam int COL_W  = 2 * NUM_LETTERS;
    localparam logic [2:0] LAST_IDX = 3'(NUM_LETTERS - 1);
    localparam logic [2:0] ROW_MAX  = 3'(NUM_ROWS - 1);
    localparam logic [1:0] C_GREEN  = 2'b10;
    localparam logic [1:0] C_YELLOW = 2'b01;

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             idx;
    logic [WORD_W-1:0]      guess_q;
    logic [WORD_W-1:0]      answer_q;
    logic [2:0]             row_q;
    logic [NUM_LETTERS-1:0] used;
    logic [COL_W-1:0]       board [NUM_ROWS];

    logic                   accept;
    logic [LETTER_W-1:0]    g_cur;
    logic [LETTER_W-1:0]    a_cur;
    logic [1:0]             col_cur;
    logic                   yel_hit;
    logic [NUM_LETTERS-1:0] yel_mask;
    logic [COL_W-1:0]       colors_nxt;
    logic [NUM_LETTERS-1:0] used_nxt;
    logic                   all_green;

    assign accept = (state == IDLE) && start && (row <= ROW_MAX);

    // Letter 0 occupies the most significant byte, so index k maps to slot NUM_LETTERS-1-k.
    always_comb begin
        g_cur   = '0;
        a_cur   = '0;
        col_cur = '0;
        for (int k = 0; k < NUM_LETTERS; k++) begin
            if (idx == 3'(k)) begin
                g_cur   = guess_q[(NUM_LETTERS-1-k)*LETTER_W +: LETTER_W];
                a_cur   = answer_q[(NUM_LETTERS-1-k)*LETTER_W +: LETTER_W];
                col_cur = colors[(NUM_LETTERS-1-k)*2 +: 2];
            end
        end
    end

    // Descending scan so the lowest unclaimed matching answer letter is the one kept.
    always_comb begin
        yel_hit  = 1'b0;
        yel_mask = '0;
        for (int j = NUM_LETTERS - 1; j >= 0; j--) begin
            if (!used[j] && answer_q[(NUM_LETTERS-1-j)*LETTER_W +: LETTER_W] == g_cur) begin
                yel_hit     = 1'b1;
                yel_mask    = '0;
                yel_mask[j] = 1'b1;
            end
        end
    end

    always_comb begin
        colors_nxt = colors;
        used_nxt   = used;
        for (int k = 0; k < NUM_LETTERS; k++) begin
            if (idx == 3'(k)) begin
                if (state == GREEN && g_cur == a_cur) begin
                    colors_nxt[(NUM_LETTERS-1-k)*2 +: 2] = C_GREEN;
                    used_nxt[k]                          = 1'b1;
                end else if (state == YELLOW && col_cur != C_GREEN && yel_hit) begin
                    colors_nxt[(NUM_LETTERS-1-k)*2 +: 2] = C_YELLOW;
                    used_nxt                             = used | yel_mask;
                end
            end
        end
    end

    always_comb begin
        all_green = 1'b1;
        for (int k = 0; k < NUM_LETTERS; k++) begin
            if (colors[k*2 +: 2] != C_GREEN) begin
                all_green = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = GREEN;
            GREEN:   if (idx == LAST_IDX) state_nxt = YELLOW;
            YELLOW:  if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            guess_q  <= '0;
            answer_q <= '0;
            row_q    <= '0;
            used     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            colors   <= '0;
            win      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        guess_q  <= guess;
                        answer_q <= answer;
                        row_q    <= row;
                        used     <= '0;
                        colors   <= '0;
                        win      <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                    end
                end
                GREEN, YELLOW: begin
                    colors <= colors_nxt;
                    used   <= used_nxt;
                    idx    <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                end
                DONE: begin
                    done <= 1'b1;
                    win  <= all_green;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The scoring write is ordered after the clear so it wins on a collision.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                board[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (clear_board) begin
                    board[r] <= '0;
                end
                if (state == DONE && row_q == 3'(r)) begin
                    board[r] <= colors;
                end
            end
        end
    end

    always_comb begin
        rd_colors = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rd_row == 3'(r)) begin
                rd_colors = board[r];
            end
        end
    end

    a_done_single: assert property (@(posedge Clk) disable iff (reset) done |=> !done);
    a_idle_not_busy: assert property (@(posedge Clk) disable iff (reset) (state == IDLE) |-> !busy);

endmodule

// File: doc/wordle_scorer.md
Name: wordle_scorer

Overview:
- Scores one completed 5-letter guess against the secret word, one letter per cycle, using standard Wordle rules: green for the right letter in the right place, yellow for a right letter in the wrong place, gray otherwise.
- Duplicate letters are handled correctly: each answer letter can be claimed only once, and greens claim first.
- Each scored row is stored in a 6-row colour board. The VGA display logic reads that board, and the game state machine uses the win flag.
- Sits between the guess-entry state machine, which writes guesses, and the display, which reads colours.

Parameters:
NUM_LETTERS, 5, letters per word (logic is written for 5; the parameter is for documentation and assertions only).
NUM_ROWS, 6, guess rows held in the board.
LETTER_W, 8, bits per letter (ASCII uppercase).

Ports:
Clk  input  1  system clock; every register updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  request to score; sampled on a rising edge only while idle.
guess  input  40  guessed word; letter 0 in [39:32], letter 4 in [7:0].
answer  input  40  secret word; same packing as guess.
row  input  3  board row to write (0-5).
clear_board  input  1  synchronous clear of all board rows.
busy  output  1  high while a scoring operation is in progress.
done  output  1  one-cycle pulse when the result is valid.
colors  output  10  result of the last scoring, 2 bits per letter; letter 0 in [9:8]. Codes: 00 gray, 01 yellow, 10 green.
win  output  1  all five letters green in the last scoring.
rd_row  input  3  display read address.
rd_colors  output  10  board contents at rd_row; combinational read.

Behaviour:
- State machine states: IDLE, GREEN, YELLOW, DONE. A 3-bit index i counts letters.
- Reset, asynchronous:
  - State goes to IDLE.
  - busy, done, win and colors go to 0.
  - All board rows are cleared to 0.
  - An operation in progress is abandoned: no done pulse, no board write.
- IDLE:
  - Scoring is accepted on an edge E0 where start=1 and row<=5.
  - On acceptance, guess, answer and row are latched and used[4:0] is cleared.
  - colors is cleared and win is cleared.
  - i is set to 0, busy goes high, and state moves to GREEN.
  - If start=1 and row>5, the request is ignored: state stays IDLE and busy stays 0.
- GREEN, edges E1 to E5, one letter per edge:
  - If guess letter i equals answer letter i, colour[i] is set to 10 and used[i] is set to 1.
  - i increments. After i=4, i goes back to 0 and state moves to YELLOW.
- YELLOW, edges E6 to E10, one letter per edge:
  - Letters with colour[i]=10 are left unchanged.
  - Otherwise, find the lowest j with used[j]=0 and answer letter j equal to guess letter i.
  - If such a j exists, colour[i] is set to 01 and used[j] is set to 1. If not, colour[i] stays 00.
  - After i=4, state moves to DONE.
- DONE, edge E11:
  - board[row] is written with the colours.
  - done is driven to 1 for exactly one cycle, from E11 to E12.
  - win is set to 1 if all five colours are 10.
  - busy falls at E11 and state returns to IDLE.
- Latency: start sampled at E0, done high after E11. Fixed 11-cycle latency, one scoring at a time.
- Output hold: colors and win are registered and hold until the next accepted start.
- start while busy is ignored. It is not queued.
- guess and answer may change after E0 without any effect on the operation in progress.
- clear_board:
  - Clears every board row on the edge where it is sampled.
  - If it coincides with the DONE write, the DONE write wins for that row and all other rows clear.
  - It does not affect colors or win.
- rd_colors: returns board[rd_row] combinationally. If rd_row>5, it returns 0.

Test Plan:
1. Exact match: answer "CRANE", guess "CRANE", row 0, start at E0 → busy=1 during E0–E11; done pulses once after E11; colors=10'h2AA; win=1; rd_row=0 reads 10'h2AA.
2. Duplicates in the guess: answer "ABIDE", guess "SPEED", row 1 → colors=10'h011 (only one E scores yellow); win=0; board row 1 reads 10'h011.
3. Green reserves before yellow: answer "THREE", guess "EERIE", row 2 → colors=10'h122 (letter 0 yellow, letter 1 gray, letters 2 and 4 green); board[2]=10'h122.
4. Ignored requests:
   - start pulsed at E5 of a running operation → still exactly one done at E11 and no second operation.
   - start with row=7 → busy stays 0, done never rises, board unchanged.
5. Board clear and collision:
   - Fill rows 0–2, then assert clear_board → all rows read 0, colors unchanged.
   - Assert clear_board on edge E11 of a row-3 scoring → row 3 holds the new result, rows 0–2 read 0.
6. Reset mid-operation: assert reset at cycle 7 of a row-4 scoring → busy, done, win and colors go to 0 immediately; no done pulse follows; rows 0–5 read 0; a new start after reset is released scores normally.
